// File: rtl/mastermind_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mastermind_pkg
//  Description : Shared types and constants for the Mastermind round
//                controller: digit/pattern types, round FSM encoding and
//                game constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package mastermind_pkg;

    typedef logic [2:0]  color_t;
    typedef logic [11:0] pattern_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_WAIT_GUESS = 3'd2,
        ST_GRADE      = 3'd3,
        ST_RELEASE    = 3'd4,
        ST_DONE       = 3'd5
    } round_state_t;

    localparam int     NUM_PEGS = 4;
    localparam color_t WIN_RED  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/Counter.sv
`default_nettype none
// ============================================================================
//  Module      : Counter
//  Description : Library up-counter with synchronous clear and count enable.
//                Clear has priority over enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module Counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count up on enable; reset and clear both return to zero.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/Register.sv
`default_nettype none
// ============================================================================
//  Module      : Register
//  Description : Library load-enable register with synchronous clear.
//                Clear has priority over load.
//  Revision    : 1.0 - initial release
// ============================================================================
module Register #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Load on enable; reset and clear both return to zero.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_q <= '0;
        end else if (i_enable) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/mastermind_round_ctrl_pattern_check.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_check
//  Description : Combinational legality check of a four-digit pattern; every
//                digit must be below NUM_COLORS.
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_check
    import mastermind_pkg::*;
#(
    parameter int NUM_COLORS = 6
) (
    input  pattern_t pattern,
    output logic     legal
);

    // One extra bit so that NUM_COLORS = 8 (every 3-bit digit legal) still fits.
    localparam logic [3:0] c_LIMIT = NUM_COLORS[3:0];

    logic [NUM_PEGS-1:0] w_digit_ok;

    for (genvar gi = 0; gi < NUM_PEGS; gi++) begin : g_digit
        assign w_digit_ok[gi] = ({1'b0, pattern[gi*3 +: 3]} < c_LIMIT);
    end

    assign legal = &w_digit_ok;

endmodule
`default_nettype wire

// File: rtl/mastermind_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mastermind_round_ctrl
//  Description : Round sequencer for the Mastermind datapath. Captures the
//                secret pattern, takes one guess per grade_it press, runs a
//                req/ack exchange with an external grader, registers the
//                red/white result and declares won/lost.
//  Revision    : 1.0 - initial release
// ============================================================================
module mastermind_round_ctrl
    import mastermind_pkg::*;
#(
    parameter int MAX_ROUNDS = 10,
    parameter int NUM_COLORS = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_game,
    input  logic        load_pattern,
    input  logic [11:0] pattern_in,
    input  logic        grade_it,
    input  logic [11:0] guess,
    output logic        grade_req,
    output logic [11:0] grade_guess,
    output logic [11:0] grade_pattern,
    input  logic        grade_ack,
    input  logic [2:0]  red,
    input  logic [2:0]  white,
    output logic [2:0]  feedback_red,
    output logic [2:0]  feedback_white,
    output logic [3:0]  round_number,
    output logic        won,
    output logic        lost,
    output logic        input_err
);

    localparam logic [3:0] c_MAX_ROUND = MAX_ROUNDS[3:0];

    round_state_t r_state;
    logic         r_grade_req;
    pattern_t     r_grade_guess;
    pattern_t     r_grade_pattern;
    logic         r_won;
    logic         r_lost;
    logic         r_input_err;

    logic         w_pattern_legal;
    logic         w_guess_legal;
    logic         w_new_game;
    logic         w_load_ok;
    logic         w_ack_ok;
    logic         w_round_inc;
    logic [3:0]   w_round;
    logic [5:0]   w_feedback;

    pattern_check #(.NUM_COLORS(NUM_COLORS)) u_pattern_check (
        .pattern (pattern_in),
        .legal   (w_pattern_legal)
    );

    pattern_check #(.NUM_COLORS(NUM_COLORS)) u_guess_check (
        .pattern (guess),
        .legal   (w_guess_legal)
    );

    // Entry into LOAD from any state that accepts start_game starts a new game.
    assign w_new_game = start_game &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                         (r_state == ST_WAIT_GUESS) || (r_state == ST_RELEASE));
    assign w_load_ok  = (r_state == ST_LOAD) && load_pattern && w_pattern_legal;
    assign w_ack_ok   = (r_state == ST_GRADE) && grade_ack;
    // Round goes 0 -> 1 on pattern capture, then +1 per non-final graded guess.
    assign w_round_inc = w_load_ok ||
                         (w_ack_ok && (red != WIN_RED) && (w_round != c_MAX_ROUND));

    Counter #(.WIDTH(4)) u_round_cnt (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_new_game),
        .i_enable (w_round_inc),
        .o_count  (w_round)
    );

    Register #(.WIDTH(6)) u_feedback_reg (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_new_game),
        .i_enable (w_ack_ok),
        .i_d      ({red, white}),
        .o_q      (w_feedback)
    );

    // Round FSM with its registered handshake, capture and outcome outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_grade_req     <= 1'b0;
            r_grade_guess   <= '0;
            r_grade_pattern <= '0;
            r_won           <= 1'b0;
            r_lost          <= 1'b0;
            r_input_err     <= 1'b0;
        end else begin
            r_input_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_game) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_pattern) begin
                        if (w_pattern_legal) begin
                            r_grade_pattern <= pattern_in;
                            r_state         <= ST_WAIT_GUESS;
                        end else begin
                            r_input_err <= 1'b1;
                        end
                    end
                end
                ST_WAIT_GUESS: begin
                    // A new-game request wins over a simultaneous press.
                    if (start_game) begin
                        r_won   <= 1'b0;
                        r_lost  <= 1'b0;
                        r_state <= ST_LOAD;
                    end else if (grade_it) begin
                        if (w_guess_legal) begin
                            r_grade_guess <= guess;
                            r_grade_req   <= 1'b1;
                            r_state       <= ST_GRADE;
                        end else begin
                            r_input_err <= 1'b1;
                            r_state     <= ST_RELEASE;
                        end
                    end
                end
                ST_GRADE: begin
                    if (grade_ack) begin
                        r_grade_req <= 1'b0;
                        if (red == WIN_RED) begin
                            r_won   <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (w_round == c_MAX_ROUND) begin
                            r_lost  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (start_game) begin
                        r_won   <= 1'b0;
                        r_lost  <= 1'b0;
                        r_state <= ST_LOAD;
                    end else if (!grade_it) begin
                        r_state <= ST_WAIT_GUESS;
                    end
                end
                ST_DONE: begin
                    if (start_game) begin
                        r_won   <= 1'b0;
                        r_lost  <= 1'b0;
                        r_state <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grade_req      = r_grade_req;
    assign grade_guess    = r_grade_guess;
    assign grade_pattern  = r_grade_pattern;
    assign feedback_red   = w_feedback[5:3];
    assign feedback_white = w_feedback[2:0];
    assign round_number   = w_round;
    assign won            = r_won;
    assign lost           = r_lost;
    assign input_err      = r_input_err;

endmodule
`default_nettype wire

// File: tb/tb_mastermind_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mastermind_round_ctrl
//  Description : Self-checking bench for mastermind_round_ctrl with a grader
//                model and an expectation queue consumed by an output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mastermind_round_ctrl;

    localparam int c_K_REQ = 0;
    localparam int c_K_RES = 1;
    localparam int c_K_ERR = 2;

    typedef struct {
        int         kind;
        logic [11:0] g;
        logic [11:0] p;
        logic [2:0]  r;
        logic [2:0]  w;
        logic [3:0]  rnd;
        logic        won;
        logic        lost;
        int          cyc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        start_game;
    logic        load_pattern;
    logic [11:0] pattern_in;
    logic        grade_it;
    logic [11:0] guess;
    logic        grade_req;
    logic [11:0] grade_guess;
    logic [11:0] grade_pattern;
    logic        grade_ack;
    logic [2:0]  red;
    logic [2:0]  white;
    logic [2:0]  feedback_red;
    logic [2:0]  feedback_white;
    logic [3:0]  round_number;
    logic        won;
    logic        lost;
    logic        input_err;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          g_delay = 1;
    logic [2:0]  g_red = 3'd0;
    logic [2:0]  g_white = 3'd0;
    logic [11:0] cur_pattern = 12'd0;
    bit          expect_abort = 1'b0;

    mastermind_round_ctrl #(.MAX_ROUNDS(10), .NUM_COLORS(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .start_game     (start_game),
        .load_pattern   (load_pattern),
        .pattern_in     (pattern_in),
        .grade_it       (grade_it),
        .guess          (guess),
        .grade_req      (grade_req),
        .grade_guess    (grade_guess),
        .grade_pattern  (grade_pattern),
        .grade_ack      (grade_ack),
        .red            (red),
        .white          (white),
        .feedback_red   (feedback_red),
        .feedback_white (feedback_white),
        .round_number   (round_number),
        .won            (won),
        .lost           (lost),
        .input_err      (input_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Grader model: ack after g_delay cycles of grade_req, abandoned if req drops.
    initial begin : grader
        int cnt;
        bit alive;
        grade_ack = 1'b0;
        red       = 3'd0;
        white     = 3'd0;
        forever begin
            @(negedge clock);
            if (grade_req && !grade_ack) begin
                cnt   = 1;
                alive = 1'b1;
                while (cnt < g_delay) begin
                    @(negedge clock);
                    if (!grade_req) begin
                        alive = 1'b0;
                        break;
                    end
                    cnt++;
                end
                if (alive) begin
                    red       = g_red;
                    white     = g_white;
                    grade_ack = 1'b1;
                    @(posedge clock);
                    #1 grade_ack = 1'b0;
                end
            end
        end
    end

    // Monitor: every request, completed grade and input error pops one expectation.
    initial begin : monitor
        logic prev_req;
        int   req_cnt;
        exp_t e;
        prev_req = 1'b0;
        req_cnt  = 0;
        forever begin
            @(negedge clock);
            if (grade_req) req_cnt++;
            if (!prev_req && grade_req) begin
                if (q.size() == 0 || q[0].kind != c_K_REQ) begin
                    check("unexpected_req", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("req_guess", 32'(grade_guess), 32'(e.g));
                    check("req_pattern", 32'(grade_pattern), 32'(e.p));
                end
            end
            if (prev_req && !grade_req) begin
                if (expect_abort) begin
                    expect_abort = 1'b0;
                end else if (q.size() == 0 || q[0].kind != c_K_RES) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("req_cycles", 32'(req_cnt), 32'(e.cyc));
                    check("feedback_red", 32'(feedback_red), 32'(e.r));
                    check("feedback_white", 32'(feedback_white), 32'(e.w));
                    check("round_number", 32'(round_number), 32'(e.rnd));
                    check("won", 32'(won), 32'(e.won));
                    check("lost", 32'(lost), 32'(e.lost));
                end
                req_cnt = 0;
            end
            if (input_err) begin
                if (q.size() == 0 || q[0].kind != c_K_ERR) begin
                    check("unexpected_input_err", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("err_round", 32'(round_number), 32'(e.rnd));
                    check("err_no_req", 32'(grade_req), 32'd0);
                end
            end
            prev_req = grade_req;
        end
    end

    task automatic push_req(input logic [11:0] g);
        exp_t e;
        e = '{kind: c_K_REQ, g: g, p: cur_pattern, r: 3'd0, w: 3'd0,
              rnd: 4'd0, won: 1'b0, lost: 1'b0, cyc: 0};
        q.push_back(e);
    endtask

    task automatic push_res(input logic [2:0] r, input logic [2:0] w, input logic [3:0] rnd,
                            input logic ew, input logic el, input int cyc);
        exp_t e;
        e = '{kind: c_K_RES, g: 12'd0, p: 12'd0, r: r, w: w,
              rnd: rnd, won: ew, lost: el, cyc: cyc};
        q.push_back(e);
    endtask

    task automatic push_err(input logic [3:0] rnd);
        exp_t e;
        e = '{kind: c_K_ERR, g: 12'd0, p: 12'd0, r: 3'd0, w: 3'd0,
              rnd: rnd, won: 1'b0, lost: 1'b0, cyc: 0};
        q.push_back(e);
    endtask

    task automatic wait_req(input logic v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (grade_req == v) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_grade_req_timeout", 32'(grade_req), 32'(v));
    endtask

    task automatic new_game();
        start_game = 1'b1;
        @(negedge clock);
        start_game = 1'b0;
        @(negedge clock);
    endtask

    task automatic load_pat(input logic [11:0] p);
        cur_pattern  = p;
        pattern_in   = p;
        load_pattern = 1'b1;
        @(negedge clock);
        load_pattern = 1'b0;
    endtask

    task automatic load_bad(input logic [11:0] p);
        push_err(4'd0);
        pattern_in   = p;
        load_pattern = 1'b1;
        @(negedge clock);
        load_pattern = 1'b0;
    endtask

    task automatic bad_guess(input logic [11:0] g, input logic [3:0] rnd);
        push_err(rnd);
        guess    = g;
        grade_it = 1'b1;
        @(negedge clock);
        grade_it = 1'b0;
        @(negedge clock);
    endtask

    task automatic play_round(input logic [11:0] g, input int dly, input logic [2:0] rd,
                              input logic [2:0] wh, input logic [3:0] rnd,
                              input logic ew, input logic el, input int hold);
        push_req(g);
        push_res(rd, wh, rnd, ew, el, dly);
        g_delay  = dly;
        g_red    = rd;
        g_white  = wh;
        guess    = g;
        grade_it = 1'b1;
        wait_req(1'b1);
        wait_req(1'b0);
        repeat (hold) @(negedge clock);
        grade_it = 1'b0;
        @(negedge clock);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset        = 1'b1;
        start_game   = 1'b0;
        load_pattern = 1'b0;
        pattern_in   = 12'd0;
        grade_it     = 1'b0;
        guess        = 12'd0;
        repeat (3) @(negedge clock);

        check("rst_grade_req", 32'(grade_req), 32'd0);
        check("rst_grade_guess", 32'(grade_guess), 32'd0);
        check("rst_grade_pattern", 32'(grade_pattern), 32'd0);
        check("rst_feedback", 32'({feedback_red, feedback_white}), 32'd0);
        check("rst_round", 32'(round_number), 32'd0);
        check("rst_won_lost_err", 32'({won, lost, input_err}), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Win on round 1 with a 3-cycle grader.
        new_game();
        load_pat(12'o0501);
        play_round(12'o0501, 3, 3'd4, 3'd0, 4'd1, 1'b1, 1'b0, 0);

        // Ten misses; first press held 20 cycles must yield a single request.
        new_game();
        check("new_game_clears_won", 32'(won), 32'd0);
        check("new_game_clears_round", 32'(round_number), 32'd0);
        load_pat(12'o1234);
        for (int k = 1; k <= 10; k++) begin
            play_round(12'o1234, 1, 3'd1, 3'd1, (k < 10) ? 4'(k + 1) : 4'd10,
                       1'b0, (k == 10), (k == 1) ? 20 : 0);
        end
        check("lost_holds", 32'({won, lost}), 32'b01);

        // Win on the final round.
        new_game();
        check("new_game_clears_lost", 32'(lost), 32'd0);
        load_pat(12'o0501);
        for (int k = 1; k <= 9; k++) begin
            play_round(12'o1234, 2, 3'd1, 3'd1, 4'(k + 1), 1'b0, 1'b0, 0);
        end
        play_round(12'o0501, 1, 3'd4, 3'd0, 4'd10, 1'b1, 1'b0, 0);

        // Illegal pattern and illegal guess.
        new_game();
        load_bad(12'o0706);
        load_pat(12'o0501);
        bad_guess(12'o0007, 4'd1);
        play_round(12'o1234, 2, 3'd1, 3'd2, 4'd2, 1'b0, 1'b0, 0);

        // start_game during GRADE is ignored; still held in RELEASE it aborts.
        push_req(12'o2345);
        push_res(3'd0, 3'd3, 4'd3, 1'b0, 1'b0, 4);
        g_delay  = 4;
        g_red    = 3'd0;
        g_white  = 3'd3;
        guess    = 12'o2345;
        grade_it = 1'b1;
        wait_req(1'b1);
        start_game = 1'b1;
        wait_req(1'b0);
        grade_it = 1'b0;
        @(negedge clock);
        check("abort_round", 32'(round_number), 32'd0);
        check("abort_feedback", 32'({feedback_red, feedback_white}), 32'd0);
        check("abort_no_req", 32'(grade_req), 32'd0);
        start_game = 1'b0;

        // Reset while a request is outstanding.
        load_pat(12'o0501);
        push_req(12'o1111);
        g_delay  = 10;
        guess    = 12'o1111;
        grade_it = 1'b1;
        wait_req(1'b1);
        @(negedge clock);
        expect_abort = 1'b1;
        reset        = 1'b1;
        @(negedge clock);
        check("rst2_grade_req", 32'(grade_req), 32'd0);
        check("rst2_pattern_guess", 32'({grade_pattern, grade_guess}), 32'd0);
        check("rst2_round_fb", 32'({round_number, feedback_red, feedback_white}), 32'd0);
        check("rst2_flags", 32'({won, lost, input_err}), 32'd0);
        reset    = 1'b0;
        grade_it = 1'b0;
        repeat (3) @(negedge clock);

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
